// File: rtl/lava_sequencer.sv
// lava_sequencer: advancing lava wall for one game level.
//
// After a level loads, the sequencer waits for the first player input. It then
// counts DELAY_TICKS game ticks and moves the wall right on every tick. The
// wall position is kept in 1/16-pixel units. The step grows with the speed
// index. The wall stops when it reaches the player, and hit_lava_wall pulses.
//
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous reset, active low
//   game_tick         one-clk frame strobe (60 Hz)
//   start_level       one-clk pulse when a level is loaded; overrides everything
//   level             current level (3 = no lava)
//   any_input_level   player is pressing any control
//   speed_boost_pulse score-based speed-up request
//   freeze            hold all state (win / game over)
//   player_x          player left edge, pixels
//   lava_wall_x       wall left edge, pixels
//   lava_active       high while the wall is moving
//   hit_lava_wall     one-clk collision pulse
//   state             OFF=0, WAIT_INPUT=1, DELAY=2, RUN=3, HALT=4
//   speed_idx         current speed-ramp index
module lava_sequencer #(
   parameter int unsigned DELAY_TICKS   = 120,
   parameter int unsigned WALL_W        = 10,
   parameter int unsigned MAX_SPEED_IDX = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_tick,
   input  logic       start_level,
   input  logic [1:0] level,
   input  logic       any_input_level,
   input  logic       speed_boost_pulse,
   input  logic       freeze,
   input  logic [9:0] player_x,
   output logic [9:0] lava_wall_x,
   output logic       lava_active,
   output logic       hit_lava_wall,
   output logic [2:0] state,
   output logic [2:0] speed_idx
);

   typedef enum logic [2:0] {
      StOff       = 3'd0,
      StWaitInput = 3'd1,
      StDelay     = 3'd2,
      StRun       = 3'd3,
      StHalt      = 3'd4
   } state_e;

   localparam logic [9:0]  XMax     = 10'(640 - WALL_W);
   localparam logic [8:0]  CntLast  = 9'(DELAY_TICKS - 1);
   localparam logic [2:0]  SpeedMax = 3'(MAX_SPEED_IDX);
   localparam logic [10:0] WallW11  = 11'(WALL_W);

   state_e      state_q, state_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [3:0]  frac_q, frac_d;
   logic [2:0]  speed_idx_q, speed_idx_d;
   logic [9:0]  wall_x_q, wall_x_d;
   logic        hit_q, hit_d;

   logic [7:0]  base;
   logic [7:0]  step;
   logic [14:0] pos_sum;
   logic        sat;
   logic [9:0]  new_x;
   logic [3:0]  new_frac;
   logic        collide;

   // Step in 1/16 pixel: level base plus 4 per speed index.
   always_comb begin
      case (level)
         2'd1:    base = 8'd12;
         2'd2:    base = 8'd16;
         default: base = 8'd8;
      endcase
      step = base + {3'b000, speed_idx_q, 2'b00};
   end

   // Candidate wall position for this tick, clamped to the right screen edge.
   always_comb begin
      pos_sum  = {1'b0, wall_x_q, frac_q} + {7'b0, step};
      sat      = pos_sum[14:4] >= {1'b0, XMax};
      new_x    = sat ? XMax : pos_sum[13:4];
      new_frac = sat ? 4'd0 : pos_sum[3:0];
      collide  = ({1'b0, new_x} + WallW11) >= {1'b0, player_x};
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      frac_d      = frac_q;
      speed_idx_d = speed_idx_q;
      wall_x_d    = wall_x_q;
      hit_d       = 1'b0;

      if (start_level) begin
         state_d     = (level == 2'd3) ? StOff : StWaitInput;
         cnt_d       = '0;
         frac_d      = '0;
         speed_idx_d = '0;
         wall_x_d    = '0;
      end else if (!freeze && game_tick) begin
         case (state_q)
            StOff: begin
               wall_x_d = '0;
               frac_d   = '0;
            end
            StWaitInput: begin
               if (any_input_level) begin
                  state_d = StDelay;
                  cnt_d   = '0;
               end
            end
            StDelay: begin
               cnt_d = cnt_q + 9'd1;
               if (cnt_q == CntLast) begin
                  state_d = StRun;
               end
            end
            StRun: begin
               wall_x_d = new_x;
               frac_d   = new_frac;
               if (collide) begin
                  hit_d   = 1'b1;
                  state_d = StHalt;
               end
            end
            default: ;
         endcase

         // The boosted index only affects the step from the next tick onward.
         if (speed_boost_pulse && (state_q == StDelay || state_q == StRun) &&
             speed_idx_q < SpeedMax) begin
            speed_idx_d = speed_idx_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StOff;
         cnt_q       <= '0;
         frac_q      <= '0;
         speed_idx_q <= '0;
         wall_x_q    <= '0;
         hit_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         frac_q      <= frac_d;
         speed_idx_q <= speed_idx_d;
         wall_x_q    <= wall_x_d;
         hit_q       <= hit_d;
      end
   end

   assign lava_wall_x   = wall_x_q;
   assign lava_active   = (state_q == StRun);
   assign hit_lava_wall = hit_q;
   assign state         = state_q;
   assign speed_idx     = speed_idx_q;

endmodule

// File: tb/tb_lava_sequencer.sv
// Testbench for lava_sequencer: scenario tasks plus a randomized run. Expected
// values come from a behavioural model that uses integer positions in 1/16 px.
module tb_lava_sequencer;

   localparam int DT = 120;
   localparam int WW = 10;
   localparam int MS = 7;
   localparam int XMAX = 640 - WW;

   logic       clk = 1'b0;
   logic       rst;
   logic       game_tick, start_level, any_input_level, speed_boost_pulse, freeze;
   logic [1:0] level;
   logic [9:0] player_x;
   logic [9:0] lava_wall_x;
   logic       lava_active, hit_lava_wall;
   logic [2:0] state, speed_idx;

   int checks = 0;
   int failures = 0;

   // Model state: 0 OFF, 1 WAIT, 2 DELAY, 3 RUN, 4 HALT.
   int m_state, m_ticks, m_p16, m_sidx, m_hit;

   lava_sequencer #(.DELAY_TICKS(DT), .WALL_W(WW), .MAX_SPEED_IDX(MS)) dut (
      .clk(clk), .rst(rst), .game_tick(game_tick), .start_level(start_level),
      .level(level), .any_input_level(any_input_level),
      .speed_boost_pulse(speed_boost_pulse), .freeze(freeze), .player_x(player_x),
      .lava_wall_x(lava_wall_x), .lava_active(lava_active),
      .hit_lava_wall(hit_lava_wall), .state(state), .speed_idx(speed_idx)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_state = 0; m_ticks = 0; m_p16 = 0; m_sidx = 0; m_hit = 0;
   endtask

   task automatic model_edge();
      int st;
      int base;
      st = m_state;
      m_hit = 0;
      base = (level == 2'd1) ? 12 : (level == 2'd2) ? 16 : 8;
      if (start_level) begin
         m_state = (level == 2'd3) ? 0 : 1;
         m_ticks = 0; m_p16 = 0; m_sidx = 0;
      end else if (!freeze && game_tick) begin
         if (st == 1 && any_input_level) begin
            m_state = 2; m_ticks = 0;
         end else if (st == 2) begin
            m_ticks++;
            if (m_ticks == DT) m_state = 3;
         end else if (st == 3) begin
            m_p16 += base + 4 * m_sidx;
            if (m_p16 / 16 >= XMAX) m_p16 = XMAX * 16;
            if (m_p16 / 16 + WW >= int'(player_x)) begin
               m_hit = 1; m_state = 4;
            end
         end
         if ((st == 2 || st == 3) && speed_boost_pulse && m_sidx < MS) m_sidx++;
      end
   endtask

   // One clock with the given inputs; the pulses drop 1 ns after the edge.
   task automatic clk_step(input bit t, input bit s, input bit a, input bit b, input bit f);
      game_tick = t; start_level = s; any_input_level = a;
      speed_boost_pulse = b; freeze = f;
      @(posedge clk);
      model_edge();
      #1;
      game_tick = 0; start_level = 0; speed_boost_pulse = 0;
   endtask

   task automatic goto_run(input int lvl, input int px);
      level = 2'(lvl); player_x = 10'(px);
      clk_step(0, 1, 0, 0, 0);
      clk_step(1, 0, 1, 0, 0);
      repeat (DT) clk_step(1, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      game_tick = 0; start_level = 0; any_input_level = 0;
      speed_boost_pulse = 0; freeze = 0; level = 0; player_x = 10'd500;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      if (state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", state); end
      checks++;
      if (lava_wall_x !== 10'd0) begin failures++; $display("FAIL reset_x: got %0d want 0", lava_wall_x); end
      checks++;
      if (speed_idx !== 3'd0 || hit_lava_wall !== 1'b0 || lava_active !== 1'b0) begin
         failures++;
         $display("FAIL reset_misc: sidx=%0d hit=%0d act=%0d want 0 0 0", speed_idx, hit_lava_wall, lava_active);
      end
      checks++;
      rst = 1'b1;
      repeat (5) clk_step(1, 0, 1, 1, 0);
      if (state !== 3'd0) begin failures++; $display("FAIL off_after_reset: got %0d want 0", state); end
      checks++;
   endtask

   task automatic test_delay_run();
      level = 0; player_x = 10'd1023;
      clk_step(0, 1, 0, 0, 0);
      if (state !== 3'd1) begin failures++; $display("FAIL start_wait: got %0d want 1", state); end
      checks++;
      clk_step(1, 0, 0, 0, 0);
      if (state !== 3'd1) begin failures++; $display("FAIL wait_no_input: got %0d want 1", state); end
      checks++;
      clk_step(1, 0, 1, 0, 0);
      if (state !== 3'd2) begin failures++; $display("FAIL enter_delay: got %0d want 2", state); end
      checks++;
      repeat (DT - 1) clk_step(1, 0, 0, 0, 0);
      if (state !== 3'd2) begin failures++; $display("FAIL delay_len_short: got %0d want 2", state); end
      checks++;
      clk_step(1, 0, 0, 0, 0);
      if (state !== 3'd3 || lava_active !== 1'b1) begin
         failures++; $display("FAIL enter_run: state=%0d act=%0d want 3 1", state, lava_active);
      end
      checks++;
      repeat (4) clk_step(1, 0, 0, 0, 0);
      if (lava_wall_x !== 10'd2) begin failures++; $display("FAIL run_4_ticks_x: got %0d want 2", lava_wall_x); end
      checks++;
      // Three more half-pixel steps: x 3 only if frac was 0 at x=2.
      repeat (3) clk_step(1, 0, 0, 0, 0);
      if (lava_wall_x !== 10'd3) begin failures++; $display("FAIL run_7_ticks_x: got %0d want 3", lava_wall_x); end
      checks++;
   endtask

   task automatic test_collision();
      goto_run(2, 20);
      repeat (8) clk_step(1, 0, 0, 0, 0);
      // Freeze with a pending tick that would otherwise move to x=9.
      repeat (3) clk_step(1, 0, 0, 0, 1);
      if (lava_wall_x !== 10'd8 || hit_lava_wall !== 1'b0) begin
         failures++; $display("FAIL coll_freeze: x=%0d hit=%0d want 8 0", lava_wall_x, hit_lava_wall);
      end
      checks++;
      clk_step(1, 0, 0, 0, 0);
      if (hit_lava_wall !== 1'b0 || state !== 3'd3) begin
         failures++; $display("FAIL coll_early: hit=%0d state=%0d want 0 3", hit_lava_wall, state);
      end
      checks++;
      clk_step(1, 0, 0, 0, 0);
      if (hit_lava_wall !== 1'b1 || state !== 3'd4 || lava_wall_x !== 10'd10) begin
         failures++;
         $display("FAIL coll_hit: hit=%0d state=%0d x=%0d want 1 4 10", hit_lava_wall, state, lava_wall_x);
      end
      checks++;
      clk_step(0, 0, 0, 0, 0);
      if (hit_lava_wall !== 1'b0) begin failures++; $display("FAIL coll_pulse_len: got %0d want 0", hit_lava_wall); end
      checks++;
      repeat (6) clk_step(1, 0, 1, 1, 0);
      if (lava_wall_x !== 10'd10 || state !== 3'd4 || speed_idx !== 3'd0 || hit_lava_wall !== 1'b0) begin
         failures++;
         $display("FAIL halt_hold: x=%0d state=%0d sidx=%0d hit=%0d want 10 4 0 0",
                  lava_wall_x, state, speed_idx, hit_lava_wall);
      end
      checks++;
   endtask

   task automatic test_boost();
      int x0;
      level = 0;
      clk_step(0, 1, 0, 0, 0);
      clk_step(1, 0, 0, 1, 0);
      if (speed_idx !== 3'd0) begin failures++; $display("FAIL boost_in_wait: got %0d want 0", speed_idx); end
      checks++;
      goto_run(0, 1023);
      clk_step(0, 0, 0, 1, 0);
      if (speed_idx !== 3'd0) begin failures++; $display("FAIL boost_no_tick: got %0d want 0", speed_idx); end
      checks++;
      repeat (9) clk_step(1, 0, 0, 1, 0);
      if (speed_idx !== 3'd7) begin failures++; $display("FAIL boost_sat: got %0d want 7", speed_idx); end
      checks++;
      // Steps 8,12,...,36,36 -> 212/16 px.
      if (lava_wall_x !== 10'd13) begin failures++; $display("FAIL boost_ramp_x: got %0d want 13", lava_wall_x); end
      checks++;
      x0 = m_p16 / 16;
      repeat (4) clk_step(1, 0, 0, 0, 0);
      if (int'(lava_wall_x) !== x0 + 9) begin
         failures++; $display("FAIL boost_speed: got %0d want %0d", lava_wall_x, x0 + 9);
      end
      checks++;
   endtask

   task automatic test_freeze();
      level = 1; player_x = 10'd1023;
      clk_step(0, 1, 0, 0, 0);
      clk_step(1, 0, 1, 0, 0);
      repeat (10) clk_step(1, 0, 0, 0, 0);
      repeat (50) clk_step(1, 0, 1, 1, 1);
      if (state !== 3'd2 || speed_idx !== 3'd0 || hit_lava_wall !== 1'b0) begin
         failures++;
         $display("FAIL freeze_delay: state=%0d sidx=%0d hit=%0d want 2 0 0", state, speed_idx, hit_lava_wall);
      end
      checks++;
      repeat (DT - 11) clk_step(1, 0, 0, 0, 0);
      if (state !== 3'd2) begin failures++; $display("FAIL freeze_cnt_hold: got %0d want 2", state); end
      checks++;
      clk_step(1, 0, 0, 0, 0);
      if (state !== 3'd3) begin failures++; $display("FAIL freeze_cnt_resume: got %0d want 3", state); end
      checks++;
      repeat (5) clk_step(1, 0, 0, 0, 0);
      repeat (50) clk_step(1, 0, 1, 1, 1);
      if (lava_wall_x !== 10'd3 || speed_idx !== 3'd0 || hit_lava_wall !== 1'b0) begin
         failures++;
         $display("FAIL freeze_run: x=%0d sidx=%0d hit=%0d want 3 0 0", lava_wall_x, speed_idx, hit_lava_wall);
      end
      checks++;
      repeat (5) clk_step(1, 0, 0, 0, 0);
      // 10 steps of 12/16 px: 7.5 px, so frac survived the freeze.
      if (lava_wall_x !== 10'd7 || int'(lava_wall_x) !== m_p16 / 16) begin
         failures++; $display("FAIL freeze_resume_x: got %0d want 7", lava_wall_x);
      end
      checks++;
   endtask

   task automatic test_start_l3();
      goto_run(2, 1023);
      repeat (5) clk_step(1, 0, 0, 0, 0);
      clk_step(1, 0, 0, 1, 0);
      level = 3;
      clk_step(1, 1, 1, 1, 0);
      if (state !== 3'd0 || lava_wall_x !== 10'd0 || speed_idx !== 3'd0 ||
          hit_lava_wall !== 1'b0 || lava_active !== 1'b0) begin
         failures++;
         $display("FAIL start_l3: state=%0d x=%0d sidx=%0d hit=%0d act=%0d want 0 0 0 0 0",
                  state, lava_wall_x, speed_idx, hit_lava_wall, lava_active);
      end
      checks++;
      repeat (3) clk_step(1, 0, 1, 1, 0);
      if (state !== 3'd0 || lava_wall_x !== 10'd0) begin
         failures++; $display("FAIL l3_stays_off: state=%0d x=%0d want 0 0", state, lava_wall_x);
      end
      checks++;
   endtask

   task automatic test_async_reset();
      goto_run(0, 1023);
      repeat (20) clk_step(1, 0, 0, 1, 0);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      if (state !== 3'd0 || lava_wall_x !== 10'd0 || speed_idx !== 3'd0 ||
          hit_lava_wall !== 1'b0 || lava_active !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: state=%0d x=%0d sidx=%0d hit=%0d act=%0d want 0 0 0 0 0",
                  state, lava_wall_x, speed_idx, hit_lava_wall, lava_active);
      end
      checks++;
      @(posedge clk);
      #3;
      rst = 1'b1;
      repeat (4) clk_step(1, 0, 1, 1, 0);
      if (state !== 3'd0) begin failures++; $display("FAIL async_off_hold: got %0d want 0", state); end
      checks++;
      level = 1;
      clk_step(0, 1, 0, 0, 0);
      if (state !== 3'd1) begin failures++; $display("FAIL async_restart: got %0d want 1", state); end
      checks++;
   endtask

   task automatic test_random();
      bit t, s, a, b, f;
      for (int i = 0; i < 4000; i++) begin
         t = ($urandom % 4) != 0;
         s = (i == 0) || (($urandom % 500) == 0);
         a = ($urandom % 8) == 0;
         b = ($urandom % 12) == 0;
         f = ($urandom % 16) == 0;
         if (s) begin
            level = 2'($urandom % 4);
            player_x = 10'($urandom_range(60, 700));
         end
         clk_step(t, s, a, b, f);
         if (int'(state) !== m_state || int'(lava_wall_x) !== m_p16 / 16 ||
             int'(speed_idx) !== m_sidx || int'(hit_lava_wall) !== m_hit) begin
            failures++;
            $display("FAIL rand[%0d]: state=%0d x=%0d sidx=%0d hit=%0d want %0d %0d %0d %0d",
                     i, state, lava_wall_x, speed_idx, hit_lava_wall,
                     m_state, m_p16 / 16, m_sidx, m_hit);
         end
         checks++;
      end
   endtask

   initial begin
      test_reset();
      test_delay_run();
      test_collision();
      test_boost();
      test_freeze();
      test_start_l3();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lava_sequencer.md
LAVA_SEQUENCER -- requirements
Module: lava_sequencer

Interface
REQ-001 SHALL have parameter DELAY_TICKS, default 120, the number of game ticks between first input and wall motion.
REQ-002 SHALL have parameter WALL_W, default 10, the wall width in pixels.
REQ-003 SHALL have parameter MAX_SPEED_IDX, default 7, the saturation value of the speed index.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock, rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port game_tick, input, 1 bit: one-clk frame-rate strobe (60 Hz).
REQ-007 SHALL have port start_level, input, 1 bit: one-clk pulse when a level is loaded.
REQ-008 SHALL have port level, input, 2 bits: current level number.
REQ-009 SHALL have port any_input_level, input, 1 bit: the player is pressing any control.
REQ-010 SHALL have port speed_boost_pulse, input, 1 bit: score-based speed-up request.
REQ-011 SHALL have port freeze, input, 1 bit: hold all state (WIN/GAME_OVER).
REQ-012 SHALL have port player_x, input, 10 bits: player left edge in pixels.
REQ-013 SHALL have port lava_wall_x, output reg, 10 bits: wall left edge in pixels.
REQ-014 SHALL have port lava_active, output, 1 bit: high exactly while state is RUN.
REQ-015 SHALL have port hit_lava_wall, output reg, 1 bit: one-clk collision pulse.
REQ-016 SHALL have port state, output, 3 bits: OFF=0, WAIT_INPUT=1, DELAY=2, RUN=3, HALT=4.
REQ-017 SHALL have port speed_idx, output reg, 3 bits: current speed-ramp index.

Function
REQ-018 The state register, delay counter (9 bit), fractional accumulator frac (4 bit), speed_idx and lava_wall_x SHALL update only on clk rising edges.
REQ-019 Except for start_level, all state changes SHALL occur only on cycles with game_tick=1.
REQ-020 start_level SHALL act on any cycle, override every other event including game_tick, and clear lava_wall_x, frac, the delay counter and speed_idx.
REQ-021 On start_level, the next state SHALL be OFF if level==3 and WAIT_INPUT otherwise.
REQ-022 With freeze=1, no register SHALL change (start_level still applies) and hit_lava_wall SHALL be 0.
REQ-023 In WAIT_INPUT, a tick with any_input_level=1 SHALL move the state to DELAY with the counter at 0.
REQ-024 In DELAY, each tick SHALL increment the counter; the tick on which the counter equals DELAY_TICKS-1 SHALL move the state to RUN, so exactly DELAY_TICKS ticks are spent in DELAY.
REQ-025 The step size SHALL be 8 bits in 1/16-pixel units: step = base + 4*speed_idx.
REQ-026 base SHALL be 8 for level 0, 12 for level 1 and 16 for level 2.
REQ-027 In RUN, each tick SHALL compute the 15-bit sum {lava_wall_x,frac}+step and write it back, saturating lava_wall_x at 640-WALL_W with frac=0.
REQ-028 In RUN, the collision test SHALL use the new wall position, computed at 11 bits: new_x+WALL_W >= player_x.
REQ-029 On collision, hit_lava_wall SHALL be 1 for that single clk and the state SHALL move to HALT.
REQ-030 HALT SHALL hold lava_wall_x, and OFF SHALL hold lava_wall_x at 0; both states SHALL be left only via start_level.
REQ-031 A speed_boost_pulse coincident with a tick in DELAY or RUN SHALL increment speed_idx, saturating at MAX_SPEED_IDX; the new index SHALL take effect from the next tick.
REQ-032 speed_boost_pulse SHALL be ignored in every other state or cycle.
REQ-033 hit_lava_wall SHALL be 0 on every cycle not covered by REQ-029.

Reset
REQ-034 While rst=0, the block SHALL set state=OFF, lava_wall_x=0, frac=0, counter=0, speed_idx=0 and hit_lava_wall=0, which are the reset values of all outputs.
REQ-035 Reset asserted mid-RUN SHALL take effect immediately, without waiting for a clock edge.
REQ-036 After rst is released, the block SHALL remain in OFF until start_level.

Verification
REQ-037 Test level=0, start_level, input on tick 1, then 120 ticks -> state=RUN; after 4 further ticks lava_wall_x=2, frac=0.
REQ-038 Test level=2, player_x=20, reach RUN -> hit_lava_wall pulses one clk on the 10th RUN tick (x=10) and state=HALT; further ticks keep x=10.
REQ-039 Test level=0, 9 boosts during RUN -> speed_idx=7 and step=36, giving x advancing 2.25 px/tick.
REQ-040 Test freeze=1 for 50 ticks in DELAY and RUN -> counter, x and frac unchanged and hit_lava_wall=0; release -> resumes from the same values.
REQ-041 Test start_level with level=3 coincident with a tick in RUN -> state=OFF, x=0, speed_idx=0, no hit pulse.
REQ-042 Test rst low mid-RUN -> all outputs at their reset values asynchronously; state stays OFF until start_level.
